// File: rtl/i2c_slave_seq.sv
// i2c_slave_seq: byte-level I2C slave sequencer running on the system clock.
// Oversamples SCL/SDA, detects START/STOP, matches the device address,
// ACKs received bytes, emits load strobes for the address/data register bank
// and serves read bytes supplied on rd_data_i.
module i2c_slave_seq #(
    parameter logic [6:0] DEV_ADDR   = 7'h42,
    parameter int         ADDR_BYTES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] data_o,
    output logic       load_addr1,
    output logic       load_addr2,
    output logic       load_data,
    output logic       rd_req,
    input  logic [7:0] rd_data_i,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE,
        DEVADR,
        ACK_DEV,
        ADDR1,
        ACK_A1,
        ADDR2,
        ACK_A2,
        WDATA,
        ACK_W,
        RDATA,
        RACK,
        WAIT_STOP
    } state_t;

    // [0] first sync flop, [1] synchronized sample, [2] history for edges
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    logic scl_rise;
    logic scl_fall;
    logic scl_high;
    logic start_det;
    logic stop_det;
    logic sda_bit;

    state_t     state_q,   state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q,   shift_d;
    logic [7:0] data_q,    data_d;
    logic       oe_q,      oe_d;
    logic       busy_q,    busy_d;
    logic       rw_q,      rw_d;
    logic       mnack_q,   mnack_d;
    logic       pend_a1_q, pend_a1_d;
    logic       pend_a2_q, pend_a2_d;
    logic       pend_w_q,  pend_w_d;
    logic       la1_q,     la1_d;
    logic       la2_q,     la2_d;
    logic       lw_q,      lw_d;
    logic       rdreq_q,   rdreq_d;

    logic [7:0] rx_byte;

    // Synchronize the pad inputs; reset to the idle-high bus level so that
    // leaving reset never fabricates an edge on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign scl_high  = scl_q[1] & scl_q[2];
    assign start_det = scl_high & sda_q[2] & ~sda_q[1];
    assign stop_det  = scl_high & ~sda_q[2] & sda_q[1];
    assign sda_bit   = sda_q[1];
    assign rx_byte   = {shift_q[6:0], sda_bit};

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
            mnack_q   <= 1'b0;
            pend_a1_q <= 1'b0;
            pend_a2_q <= 1'b0;
            pend_w_q  <= 1'b0;
            la1_q     <= 1'b0;
            la2_q     <= 1'b0;
            lw_q      <= 1'b0;
            rdreq_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            mnack_q   <= mnack_d;
            pend_a1_q <= pend_a1_d;
            pend_a2_q <= pend_a2_d;
            pend_w_q  <= pend_w_d;
            la1_q     <= la1_d;
            la2_q     <= la2_d;
            lw_q      <= lw_d;
            rdreq_q   <= rdreq_d;
        end
    end

    // Next-state logic: bus conditions first (STOP beats everything), then
    // per-state bit handling on the synchronized SCL edges.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        mnack_d   = mnack_q;
        pend_a1_d = 1'b0;
        pend_a2_d = 1'b0;
        pend_w_d  = 1'b0;
        la1_d     = pend_a1_q;
        la2_d     = pend_a2_q;
        lw_d      = pend_w_q;
        rdreq_d   = 1'b0;

        if (stop_det) begin
            state_d   = IDLE;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (start_det) begin
            state_d   = DEVADR;
            oe_d      = 1'b0;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                DEVADR, ADDR1, ADDR2, WDATA: begin
                    if (scl_rise && (bit_cnt_q < 4'd8)) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            data_d = rx_byte;
                            case (state_q)
                                DEVADR: begin
                                    if (rx_byte[7:1] != DEV_ADDR) begin
                                        state_d = WAIT_STOP;
                                        busy_d  = 1'b0;
                                    end else begin
                                        busy_d = 1'b1;
                                        rw_d   = rx_byte[0];
                                    end
                                end
                                ADDR1:   pend_a1_d = 1'b1;
                                ADDR2:   pend_a2_d = 1'b1;
                                WDATA:   pend_w_d  = 1'b1;
                                default: ;
                            endcase
                        end
                    end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                        oe_d      = 1'b1;
                        bit_cnt_d = 4'd0;
                        case (state_q)
                            DEVADR:  state_d = ACK_DEV;
                            ADDR1:   state_d = ACK_A1;
                            ADDR2:   state_d = ACK_A2;
                            default: state_d = ACK_W;
                        endcase
                    end
                end

                ACK_DEV: begin
                    if (scl_fall) begin
                        oe_d      = 1'b0;
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d = RDATA;
                            rdreq_d = 1'b1;
                        end else begin
                            state_d = ADDR1;
                        end
                    end
                end

                ACK_A1: begin
                    if (scl_fall) begin
                        oe_d      = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = (ADDR_BYTES == 1) ? WDATA : ADDR2;
                    end
                end

                ACK_A2, ACK_W: begin
                    if (scl_fall) begin
                        oe_d      = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = WDATA;
                    end
                end

                RDATA: begin
                    if (rdreq_q) begin
                        // SCL is low here, so the MSB goes straight onto the line
                        shift_d   = rd_data_i;
                        oe_d      = ~rd_data_i[7];
                        bit_cnt_d = 4'd0;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            oe_d      = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = RACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            oe_d      = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                RACK: begin
                    if (scl_rise) begin
                        mnack_d = sda_bit;
                    end else if (scl_fall) begin
                        oe_d      = 1'b0;
                        bit_cnt_d = 4'd0;
                        if (mnack_q) begin
                            state_d = WAIT_STOP;
                        end else begin
                            state_d = RDATA;
                            rdreq_d = 1'b1;
                        end
                    end
                end

                WAIT_STOP: oe_d = 1'b0;

                default: oe_d = 1'b0;
            endcase
        end
    end

    assign sda_oe     = oe_q;
    assign data_o     = data_q;
    assign load_addr1 = la1_q;
    assign load_addr2 = la2_q;
    assign load_data  = lw_q;
    assign rd_req     = rdreq_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_seq.sv
// tb_i2c_slave_seq: directed I2C master transactions against two slave
// instances (2-byte and 1-byte register addressing) sharing one master.
module tb_i2c_slave_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic scl_m;
    logic sda_m;
    logic sel;
    logic sda_line;

    logic scl_a, sda_a, scl_b, sda_b;
    logic oe_a, oe_b;
    logic [7:0] data_a, data_b;
    logic a1_a, a2_a, ld_a, rr_a, busy_a;
    logic a1_b, a2_b, ld_b, rr_b, busy_b;
    logic [7:0] rd_data_a;

    logic act_oe, act_a1, act_a2, act_ld, act_rr, act_busy;
    logic [7:0] act_data;

    int compared   = 0;
    int mismatched = 0;

    int a1Cnt = 0, a2Cnt = 0, ldCnt = 0, rrCnt = 0, oeCnt = 0;
    logic [7:0] a1Val = 8'h00;
    logic [7:0] a2Val = 8'h00;
    logic [7:0] ldVals [16];

    int b_a1, b_a2, b_ld, b_rr, b_oe;

    // open-drain bus: master and selected slave wired-AND; idle slave sees a quiet bus
    assign sda_line = sda_m & ~(sel ? oe_b : oe_a);
    assign scl_a    = sel ? 1'b1 : scl_m;
    assign sda_a    = sel ? 1'b1 : sda_line;
    assign scl_b    = sel ? scl_m : 1'b1;
    assign sda_b    = sel ? sda_line : 1'b1;

    assign act_oe   = sel ? oe_b   : oe_a;
    assign act_a1   = sel ? a1_b   : a1_a;
    assign act_a2   = sel ? a2_b   : a2_a;
    assign act_ld   = sel ? ld_b   : ld_a;
    assign act_rr   = sel ? rr_b   : rr_a;
    assign act_busy = sel ? busy_b : busy_a;
    assign act_data = sel ? data_b : data_a;

    // register file model: first read request returns 0x5A, later ones 0xC3
    assign rd_data_a = (rrCnt == 1) ? 8'h5A : 8'hC3;

    i2c_slave_seq #(.DEV_ADDR(7'h42), .ADDR_BYTES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_a), .sda_i(sda_a),
        .sda_oe(oe_a), .data_o(data_a), .load_addr1(a1_a), .load_addr2(a2_a),
        .load_data(ld_a), .rd_req(rr_a), .rd_data_i(rd_data_a), .busy(busy_a)
    );

    i2c_slave_seq #(.DEV_ADDR(7'h42), .ADDR_BYTES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_b), .sda_i(sda_b),
        .sda_oe(oe_b), .data_o(data_b), .load_addr1(a1_b), .load_addr2(a2_b),
        .load_data(ld_b), .rd_req(rr_b), .rd_data_i(8'h00), .busy(busy_b)
    );

    // strobe and drive monitor, sampled on the inactive clock edge
    always @(negedge clk) begin
        if (act_a1) begin
            a1Cnt <= a1Cnt + 1;
            a1Val <= act_data;
        end
        if (act_a2) begin
            a2Cnt <= a2Cnt + 1;
            a2Val <= act_data;
        end
        if (act_ld) begin
            ldCnt <= ldCnt + 1;
            ldVals[ldCnt[3:0]] <= act_data;
        end
        if (act_rr) rrCnt <= rrCnt + 1;
        if (act_oe) oeCnt <= oeCnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic scl, input logic sda, input int clks);
        scl_m = scl;
        sda_m = sda;
        repeat (clks) @(negedge clk);
    endtask

    task automatic takeSnapshot();
        b_a1 = a1Cnt;
        b_a2 = a2Cnt;
        b_ld = ldCnt;
        b_rr = rrCnt;
        b_oe = oeCnt;
    endtask

    task automatic sendStart();
        applyStimulus(1'b0, sda_m, 8);
        applyStimulus(1'b0, 1'b1, 8);
        applyStimulus(1'b1, 1'b1, 16);
        applyStimulus(1'b1, 1'b0, 16);
    endtask

    task automatic sendStop();
        applyStimulus(1'b0, sda_m, 8);
        applyStimulus(1'b0, 1'b0, 8);
        applyStimulus(1'b1, 1'b0, 16);
        applyStimulus(1'b1, 1'b1, 16);
    endtask

    task automatic sendBit(input logic b);
        applyStimulus(1'b0, sda_m, 8);
        applyStimulus(1'b0, b, 8);
        applyStimulus(1'b1, b, 16);
    endtask

    task automatic sendByte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) sendBit(b[i]);
        applyStimulus(1'b0, sda_m, 8);
        applyStimulus(1'b0, 1'b1, 8);
        applyStimulus(1'b1, 1'b1, 8);
        ack = sda_line;
        applyStimulus(1'b1, 1'b1, 8);
    endtask

    task automatic readByte(input logic mack, output logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b0, sda_m, 8);
            applyStimulus(1'b0, 1'b1, 8);
            applyStimulus(1'b1, 1'b1, 8);
            v[i] = sda_line;
            applyStimulus(1'b1, 1'b1, 8);
        end
        applyStimulus(1'b0, 1'b1, 8);
        applyStimulus(1'b0, mack, 8);
        applyStimulus(1'b1, mack, 16);
    endtask

    initial begin
        logic ack;
        logic [7:0] rv;

        rst_n = 1'b0;
        sel   = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("reset sda_oe", act_oe, 0);
        checkOutput("reset data_o", act_data, 8'h00);
        checkOutput("reset busy", act_busy, 0);
        checkOutput("reset strobes", {a1_a, a2_a, ld_a, rr_a}, 4'b0000);

        $display("[TB] write with 2-byte address");
        takeSnapshot();
        sendStart();
        sendByte(8'h84, ack); checkOutput("w2 ack dev", ack, 0);
        checkOutput("w2 busy set", act_busy, 1);
        sendByte(8'h12, ack); checkOutput("w2 ack a1", ack, 0);
        sendByte(8'h34, ack); checkOutput("w2 ack a2", ack, 0);
        sendByte(8'hAB, ack); checkOutput("w2 ack d0", ack, 0);
        sendByte(8'hCD, ack); checkOutput("w2 ack d1", ack, 0);
        sendStop();
        checkOutput("w2 a1 count", a1Cnt - b_a1, 1);
        checkOutput("w2 a1 value", a1Val, 8'h12);
        checkOutput("w2 a2 count", a2Cnt - b_a2, 1);
        checkOutput("w2 a2 value", a2Val, 8'h34);
        checkOutput("w2 ld count", ldCnt - b_ld, 2);
        checkOutput("w2 ld value0", ldVals[b_ld[3:0]], 8'hAB);
        checkOutput("w2 ld value1", ldVals[b_ld[3:0] + 4'd1], 8'hCD);
        checkOutput("w2 busy clear", act_busy, 0);
        checkOutput("w2 sda released", act_oe, 0);

        $display("[TB] address mismatch");
        takeSnapshot();
        sendStart();
        sendByte(8'h86, ack); checkOutput("mm no ack dev", ack, 1);
        checkOutput("mm busy low", act_busy, 0);
        sendByte(8'h55, ack); checkOutput("mm no ack byte", ack, 1);
        sendStop();
        checkOutput("mm oe cycles", oeCnt - b_oe, 0);
        checkOutput("mm strobes", (a1Cnt - b_a1) + (a2Cnt - b_a2) + (ldCnt - b_ld) + (rrCnt - b_rr), 0);

        $display("[TB] random read");
        takeSnapshot();
        sendStart();
        sendByte(8'h84, ack); checkOutput("rd ack dev w", ack, 0);
        sendByte(8'h00, ack); checkOutput("rd ack a1", ack, 0);
        sendByte(8'h10, ack); checkOutput("rd ack a2", ack, 0);
        sendStart();
        sendByte(8'h85, ack); checkOutput("rd ack dev r", ack, 0);
        checkOutput("rd busy", act_busy, 1);
        readByte(1'b0, rv); checkOutput("rd byte0", rv, 8'h5A);
        readByte(1'b1, rv); checkOutput("rd byte1", rv, 8'hC3);
        checkOutput("rd released after nack", act_oe, 0);
        sendStop();
        checkOutput("rd a1 value", a1Val, 8'h00);
        checkOutput("rd a2 value", a2Val, 8'h10);
        checkOutput("rd a1 a2 count", (a1Cnt - b_a1) * 16 + (a2Cnt - b_a2), 17);
        checkOutput("rd req count", rrCnt - b_rr, 2);
        checkOutput("rd no load_data", ldCnt - b_ld, 0);
        checkOutput("rd busy clear", act_busy, 0);

        $display("[TB] 1-byte address instance");
        sel = 1'b1;
        repeat (4) @(negedge clk);
        takeSnapshot();
        sendStart();
        sendByte(8'h84, ack); checkOutput("w1 ack dev", ack, 0);
        sendByte(8'h07, ack); checkOutput("w1 ack a1", ack, 0);
        sendByte(8'h99, ack); checkOutput("w1 ack d0", ack, 0);
        sendStop();
        checkOutput("w1 a1 count", a1Cnt - b_a1, 1);
        checkOutput("w1 a1 value", a1Val, 8'h07);
        checkOutput("w1 a2 never", a2Cnt - b_a2, 0);
        checkOutput("w1 ld count", ldCnt - b_ld, 1);
        checkOutput("w1 ld value", ldVals[b_ld[3:0]], 8'h99);
        sel = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] reset abort mid-byte");
        sendStart();
        sendByte(8'h84, ack); checkOutput("ab ack dev", ack, 0);
        sendBit(1'b0); sendBit(1'b0); sendBit(1'b0); sendBit(1'b1);
        applyStimulus(1'b0, sda_m, 8);
        applyStimulus(1'b0, 1'b0, 8);
        applyStimulus(1'b1, 1'b0, 8);
        rst_n = 1'b0;
        #1;
        checkOutput("ab sda_oe", act_oe, 0);
        checkOutput("ab data_o", act_data, 8'h00);
        checkOutput("ab busy", act_busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sendStop();
        takeSnapshot();
        sendStart();
        sendByte(8'h84, ack); checkOutput("ab2 ack dev", ack, 0);
        sendByte(8'h12, ack); checkOutput("ab2 ack a1", ack, 0);
        sendByte(8'h34, ack); checkOutput("ab2 ack a2", ack, 0);
        sendByte(8'h56, ack); checkOutput("ab2 ack d0", ack, 0);
        sendStop();
        checkOutput("ab2 a1 value", a1Val, 8'h12);
        checkOutput("ab2 a2 value", a2Val, 8'h34);
        checkOutput("ab2 ld count", ldCnt - b_ld, 1);
        checkOutput("ab2 ld value", ldVals[b_ld[3:0]], 8'h56);

        $display("[TB] STOP mid data byte");
        sendStart();
        sendByte(8'h84, ack);
        sendByte(8'h12, ack);
        sendByte(8'h34, ack);
        takeSnapshot();
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
        sendStop();
        repeat (8) @(negedge clk);
        checkOutput("sp no load_data", ldCnt - b_ld, 0);
        checkOutput("sp sda_oe", act_oe, 0);
        checkOutput("sp busy", act_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/i2c_slave_seq.md
Name: i2c_slave_seq

Overview:
- Byte-level I2C slave sequencer, running on the system clock.
- Oversamples SCL/SDA and detects START/STOP. Matches the device address, ACKs, and shifts bytes.
- Issues the load strobes that sequence the address registers (addr1, addr2) and the data write path.
- Also serves read bytes from the register file. Sits between the I2C pads and the address/data register bank.

Parameters:
- DEV_ADDR, 7'h42, 7-bit slave address matched in the first byte.
- ADDR_BYTES, 2, number of register-address bytes after a write header (1 or 2).

Ports:
- clk  in  1  system clock, at least 16x the SCL frequency
- rst_n  in  1  reset, asynchronous, active-low
- scl_i  in  1  raw SCL from pad (asynchronous)
- sda_i  in  1  raw SDA from pad (asynchronous)
- sda_oe  out  1  1 = pull SDA low (open-drain enable)
- data_o  out  8  last received byte, MSB first on the wire
- load_addr1  out  1  1-clk strobe: data_o is register-address byte 1
- load_addr2  out  1  1-clk strobe: data_o is register-address byte 2
- load_data  out  1  1-clk strobe: data_o is a write-data byte
- rd_req  out  1  1-clk strobe: provide next read byte on rd_data_i
- rd_data_i  in  8  read byte, sampled the clk after rd_req
- busy  out  1  high from the addressed START until STOP

Behaviour:
- Reset values: sda_oe=0, data_o=8'h00, all strobes 0, busy=0, state IDLE, bit counter 0.
- Input conditioning and edge detection:
  - scl_i and sda_i each pass through a 2-FF synchronizer, then a third history flop.
  - Edges are derived from the synchronized samples, giving 2-3 clk detection latency.
- START/STOP detection:
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
  - START from any state: go to DEVADR, bit count = 0, sda_oe = 0.
  - STOP from any state: go to IDLE, sda_oe = 0, busy = 0.
  - A repeated START is a START.
- Bit timing:
  - Bits are sampled on the synchronized SCL rising edge.
  - sda_oe changes only on the synchronized SCL falling edge.
- States: IDLE, DEVADR, ACK_DEV, ADDR1, ACK_A1, ADDR2, ACK_A2, WDATA, ACK_W, RDATA, RACK, WAIT_STOP.
- Byte receive (DEVADR/ADDR1/ADDR2/WDATA):
  - 8 bits shift MSB first.
  - On the 8th rising edge, data_o is updated, and the strobe fires the next clk (ADDR1 -> load_addr1, ADDR2 -> load_addr2, WDATA -> load_data).
  - On the following SCL fall, enter the ACK state with sda_oe=1.
  - On the next SCL fall (end of 9th clock), set sda_oe=0 and go to the next byte state.
- DEVADR outcome:
  - Upper 7 bits != DEV_ADDR: go to WAIT_STOP, no ACK, no strobes, busy stays 0.
  - Match: busy=1, ACK.
  - R/W=0: next state ADDR1.
  - R/W=1: rd_req pulses at the ACK-end SCL fall, then RDATA.
  - No strobe is issued for the device-address byte.
- Write sequencing:
  - ADDR1 -> ADDR2 (skipped when ADDR_BYTES=1; load_addr2 never fires) -> WDATA.
  - WDATA repeats until STOP or START; one load_data per byte.
- Read sequencing:
  - rd_data_i is latched into the shift register the clk after rd_req.
  - The first bit is driven immediately (sda_oe = ~bit7, since the SCL is low).
  - Each subsequent SCL fall drives the next bit.
  - After 8 bits, sda_oe=0 (released) for the master ACK slot, sampled on the 9th rising edge.
  - ACK (0): rd_req at that 9th SCL fall, next byte.
  - NACK (1): WAIT_STOP with sda_oe=0.
- WAIT_STOP: ignores everything except START/STOP; sda_oe held 0.
- Async reset mid-transfer: immediate return to reset values; the SDA line is released.
- Simultaneous STOP and SCL edge: STOP wins.

Test Plan:
- Write, 2-byte address: START, 0x84, 0x12, 0x34, 0xAB, 0xCD, STOP -> ACK on all 5 bytes; load_addr1 with data_o=0x12; load_addr2 with 0x34; load_data with 0xAB then 0xCD; busy 1 then 0 after STOP.
- Address mismatch: START, 0x86, 0x55, STOP -> sda_oe never asserted, no strobes, busy=0.
- Random read: START 0x84, 0x00, 0x10, repeated START, 0x85, rd_data_i=0x5A then 0xC3, master ACK then NACK, STOP -> load_addr1/2 with 0x00/0x10, two rd_req, SDA carries 0x5A then 0xC3, release after NACK.
- ADDR_BYTES=1: START 0x84, 0x07, 0x99, STOP -> load_addr1 (0x07), load_data (0x99), load_addr2 never pulses.
- Abort: assert rst_n=0 during the 5th bit of 0x12, release, then a full write transfer -> outputs at reset values immediately; the next transfer completes normally.
- STOP mid-byte after 3 bits of the data byte -> IDLE, no load_data, sda_oe=0.
